// File: rtl/gpio_out_if.sv
// CPU-side bus of the general-purpose output block: request/ready handshake,
// channel address and byte data in both directions.
interface gpio_out_if #(
  parameter int AW = 1
);
  logic          read;
  logic          write;
  logic          ready_r;
  logic          ready_w;
  logic [AW-1:0] address;
  logic [7:0]    data_in;
  logic [7:0]    data_out;

  modport master (
    output read, write, address, data_in,
    input  ready_r, ready_w, data_out
  );

  modport slave (
    input  read, write, address, data_in,
    output ready_r, ready_w, data_out
  );
endinterface

// File: rtl/gpio_out.sv
// General-purpose output block: CPU loads per-channel bytes, consumers drain them.
// Optional drain interrupt enabled by defining GPIO_OUT_IRQ_EN.
module gpio_out #(
  parameter int size_addr = 0,
  parameter int size      = 1
) (
  input  logic              clk,
  input  logic              reset,
  gpio_out_if.slave         bus,
  input  logic [size-1:0]   port_read,
  output logic [size*8-1:0] port_out,
  output logic [size-1:0]   port_valid
`ifdef GPIO_OUT_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int AW = (size_addr > 0) ? size_addr : 1;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [size];
  logic [7:0]      mem_d [size];
  logic [size-1:0] valid_q, valid_d;
  logic [size-1:0] sel;
  logic [size-1:0] load;
  logic            ready_r_q, ready_r_d;
  logic            ready_w_q, ready_w_d;
  logic            can_load;
  logic [7:0]      data_out_c;

  // One-hot channel select; an out-of-range address selects nothing.
  always_comb begin
    sel = '0;
    for (int i = 0; i < size; i++) begin
      sel[i] = (size_addr == 0) ? 1'b1 : (bus.address == AW'(i));
    end
  end

  // A write to an unmapped address is accepted immediately and dropped.
  assign can_load = (|(sel & (~valid_q | port_read))) | ~(|sel);

  always_comb begin
    state_d   = state_q;
    ready_w_d = 1'b0;
    load      = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.write && !ready_w_q) begin
          if (can_load) begin
            load      = sel;
            ready_w_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (can_load) begin
          load      = sel;
          ready_w_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < size; i++) begin
      mem_d[i]   = load[i] ? bus.data_in : mem_q[i];
      valid_d[i] = load[i] | (valid_q[i] & ~port_read[i]);
    end

    ready_r_d = bus.read & ~ready_r_q;
  end

  always_comb begin
    data_out_c = '0;
    for (int i = 0; i < size; i++) begin
      if (sel[i]) data_out_c = data_out_c | mem_q[i];
    end
  end

  always_comb begin
    port_out = '0;
    for (int i = 0; i < size; i++) begin
      port_out[i*8 +: 8] = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      valid_q   <= '0;
      ready_r_q <= 1'b0;
      ready_w_q <= 1'b0;
      for (int i = 0; i < size; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      ready_r_q <= ready_r_d;
      ready_w_q <= ready_w_d;
      for (int i = 0; i < size; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.ready_r  = ready_r_q;
  assign bus.ready_w  = ready_w_q;
  assign bus.data_out = data_out_c;
  assign port_valid   = valid_q;

`ifdef GPIO_OUT_IRQ_EN
  logic irq_q, irq_d;
  logic drained;

  // Set on any valid 1->0 transition; a new drain beats a simultaneous CPU read.
  always_comb begin
    drained = |(valid_q & ~valid_d);
    irq_d   = drained | (irq_q & ~(bus.read & ~ready_r_q));
  end

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: doc/gpio_out.md
Name: gpio_out

Overview:
- General-purpose output block: the CPU writes bytes into per-channel output registers over the 8-bit memory-mapped bus, and external consumers drain them through a valid/read handshake.
- It is the transmit-side counterpart of the general input block and shares its bus signalling (read/write held until ready, ready pulses).
- A channel holds one byte. A CPU write to a full channel stalls until the consumer drains that channel.

Parameters:
- size_addr, 0, address width in bits. 0 means a single channel and the address bus is ignored.
- size, 1, number of output channels. Must satisfy size <= 2**size_addr, and size = 1 when size_addr = 0.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- read  input  1  CPU read request, held until ready_r
- write  input  1  CPU write request, held until ready_w
- ready_r  output  1  read done pulse, registered
- ready_w  output  1  write accepted pulse, registered
- address  input  max(size_addr,1)  channel select, stable while request held
- data_in  input  8  write data
- data_out  output  8  last byte written to the addressed channel
- port_read  input  size  per-channel consume strobe from the consumer
- port_out  output  size*8  channel i byte on bits [i*8+7:i*8]
- port_valid  output  size  channel i holds an unconsumed byte

Behaviour:
- Reset (synchronous, wins over everything):
  - all channel registers = 8'h00
  - port_valid = 0
  - ready_r = 0, ready_w = 0
  - write FSM = IDLE
  - any pending write is discarded
- Channel select: ch = address when size_addr != 0, else ch = 0. An address >= size is accepted and ignored: the write completes and the read returns 8'h00.
- data_out is combinational and equals mem[ch]. port_out is driven continuously from mem.
- Read path:
  - ready_r <= read && !ready_r, so the pulse lasts 1 cycle and read latency is 1 cycle.
  - Reads never stall and do not affect port_valid.
- Write FSM, state IDLE:
  - On write && !ready_w: if port_valid[ch] = 0, or port_read[ch] = 1 in the same cycle, do all of the following at the next edge: mem[ch] <= data_in, port_valid[ch] <= 1, ready_w <= 1. Stay in IDLE.
  - Otherwise go to WAIT. ready_w stays 0.
- Write FSM, state WAIT:
  - The CPU holds write, address and data_in stable.
  - When port_valid[ch] = 0 or port_read[ch] = 1, perform the same load and ready_w pulse, then return to IDLE.
- ready_w is a single-cycle pulse. The CPU drops write in the cycle after ready_w.
- Consumer side, per channel i:
  - port_read[i] && port_valid[i] with no load to i in the same cycle: port_valid[i] <= 0 next edge.
  - Consume and load in the same cycle: the new byte replaces the old one and port_valid[i] stays 1.
  - port_read[i] while port_valid[i] = 0 is ignored.
- Simultaneous read and write: both are serviced independently. data_out shows the old value until the load edge.
- Consumer contract: the consumer samples port_out[i] in the same cycle that it asserts port_read[i].
- Reset while in WAIT: return to IDLE, and no ready_w is issued.

Optional Feature:
- GPIO_OUT_IRQ_EN defined:
  - Adds output irq (1 bit, registered).
  - irq <= 1 when any channel is drained, i.e. port_valid[i] falls 1->0. It stays 1 until a CPU read of any channel clears it.
  - If a set event and a clear event occur in the same cycle, the set wins.
  - Reset value of irq is 0.
- GPIO_OUT_IRQ_EN undefined: no irq port and no associated logic.

Test Plan:
- Reset, then write 8'hA5 to ch0 → ready_w high exactly 1 cycle later; port_out[7:0] = 8'hA5; port_valid[0] = 1.
- Read ch0 after the above → ready_r pulse 1 cycle after read; data_out = 8'hA5; port_valid[0] unchanged.
- Write 8'h11 then 8'h22 to ch0 with no port_read → second write stalls and ready_w stays 0 for 5 cycles. Pulse port_read[0] → next edge: port_out = 8'h22, port_valid[0] = 1, ready_w pulse.
- size_addr = 2, size = 3: write 8'h33 to ch2 and pulse port_read[1] while ch1 is empty → port_valid = 3'b100 and port_read[1] is ignored. A write to address 3 acks within 1 cycle, and a read of address 3 returns 8'h00.
- Stall a write to ch1, then assert reset mid-WAIT → all port_valid = 0, no ready_w, and a subsequent write acks within 1 cycle.
- GPIO_OUT_IRQ_EN: drain ch0 via port_read → irq = 1 on the next edge; CPU read → irq = 0. A drain in the same cycle as the read → irq stays 1.
